// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank arbiter slice.
package regbank_pkg;

  localparam int REGBANK_DATA_W   = 32;
  localparam int REGBANK_ADDR_W   = 2;
  localparam int REGBANK_NUM_REGS = 4;

  // Identifies a requester; also encodes which client holds write priority.
  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

endpackage

// File: rtl/regbank_rsp_slot.sv
// One-entry response register for a single client. Free when empty or being
// popped this cycle, so a pop and a push can share the same cycle.
module regbank_rsp_slot
  import regbank_pkg::*;
#(
  parameter int DATA_W = REGBANK_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              push_we,
  input  logic [DATA_W-1:0] push_rdata,
  input  logic              rsp_ready,
  output logic              free,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata
);

  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign free      = !valid_q || rsp_ready;
  assign rsp_valid = valid_q;
  assign rsp_we    = we_q;
  assign rsp_rdata = rdata_q;

  // Load on push; otherwise drop valid once the client takes the response.
  // Payload is left untouched on release so it is stable while valid.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    if (push) begin
      valid_d = 1'b1;
      we_d    = push_we;
      rdata_d = push_rdata;
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Shares a 2-read/1-write register bank between clients A and B.
// A owns read port 1, B owns read port 2; writes are arbitrated onto the
// single write port. Define REGBANK_ARB_FIXED_PRIO_EN to make A always win
// write contention (no round-robin pointer is built in that case).
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int DATA_W = REGBANK_DATA_W,
  parameter int ADDR_W = REGBANK_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_a,
  output logic              req_ready_a,
  input  logic              req_we_a,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [DATA_W-1:0] req_wdata_a,
  input  logic              req_valid_b,
  output logic              req_ready_b,
  input  logic              req_we_b,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata_b,
  output logic              rsp_valid_a,
  input  logic              rsp_ready_a,
  output logic              rsp_we_a,
  output logic [DATA_W-1:0] rsp_rdata_a,
  output logic              rsp_valid_b,
  input  logic              rsp_ready_b,
  output logic              rsp_we_b,
  output logic [DATA_W-1:0] rsp_rdata_b,
  output logic [ADDR_W-1:0] sr1,
  output logic [ADDR_W-1:0] sr2,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2,
  output logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] wrData,
  output logic              write
);

  logic free_a, free_b;
  logic cand_a, cand_b;
  logic wr_grant_a, wr_grant_b;
  logic acc_a, acc_b;

  // Read selects follow the request addresses directly.
  assign sr1 = req_addr_a;
  assign sr2 = req_addr_b;

  // Gating with rst_n keeps the bank write and handshakes dead during reset,
  // including the cycle in which reset is asserted mid-operation.
  assign cand_a = rst_n && req_valid_a && req_we_a && free_a;
  assign cand_b = rst_n && req_valid_b && req_we_b && free_b;

`ifdef REGBANK_ARB_FIXED_PRIO_EN
  // A wins any write contention.
  always_comb begin
    wr_grant_a = cand_a;
    wr_grant_b = cand_b && !cand_a;
  end
`else
  client_e prio_q, prio_d;

  // Round-robin write grant; pointer favours the client that lost last time.
  always_comb begin
    wr_grant_a = 1'b0;
    wr_grant_b = 1'b0;
    if (cand_a && cand_b) begin
      wr_grant_a = (prio_q == CLIENT_A);
      wr_grant_b = (prio_q == CLIENT_B);
    end else begin
      wr_grant_a = cand_a;
      wr_grant_b = cand_b;
    end
  end

  // Pointer moves only on a granted write, to the non-granted client.
  always_comb begin
    prio_d = prio_q;
    if (wr_grant_a)      prio_d = CLIENT_B;
    else if (wr_grant_b) prio_d = CLIENT_A;
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= CLIENT_A;
    else        prio_q <= prio_d;
  end
`endif

  // Readiness may look at we combinationally; reads only need a free slot.
  always_comb begin
    req_ready_a = rst_n && free_a && (!req_we_a || wr_grant_a);
    req_ready_b = rst_n && free_b && (!req_we_b || wr_grant_b);
    acc_a       = req_valid_a && req_ready_a;
    acc_b       = req_valid_b && req_ready_b;
  end

  // Bank write port: winner's fields, A's fields when idle.
  always_comb begin
    write  = wr_grant_a || wr_grant_b;
    dr     = wr_grant_b ? req_addr_b  : req_addr_a;
    wrData = wr_grant_b ? req_wdata_b : req_wdata_a;
  end

  regbank_rsp_slot #(.DATA_W(DATA_W)) u_slot_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (acc_a),
    .push_we    (req_we_a),
    .push_rdata (req_we_a ? '0 : rdData1),
    .rsp_ready  (rsp_ready_a),
    .free       (free_a),
    .rsp_valid  (rsp_valid_a),
    .rsp_we     (rsp_we_a),
    .rsp_rdata  (rsp_rdata_a)
  );

  regbank_rsp_slot #(.DATA_W(DATA_W)) u_slot_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (acc_b),
    .push_we    (req_we_b),
    .push_rdata (req_we_b ? '0 : rdData2),
    .rsp_ready  (rsp_ready_b),
    .free       (free_b),
    .rsp_valid  (rsp_valid_b),
    .rsp_we     (rsp_we_b),
    .rsp_rdata  (rsp_rdata_b)
  );

endmodule
